// File: rtl/irom_arb.sv
// Arbiter/sequencer sharing a 1-cycle-latency ROM between IFU fetch and LSU reads.
// Optional perf counters (ConflictCount, SpillCount) are enabled with IROM_ARB_PERF_EN.
module irom_arb #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IFUReq,
    input  logic [XLEN-1:0]       IFUAdr,
    output logic                  IFUReady,
    output logic                  IFUValid,
    output logic [31:0]           IFURData,
    input  logic                  LSUReq,
    input  logic [XLEN-1:0]       LSUAdr,
    output logic                  LSUReady,
    output logic                  LSUValid,
    output logic [XLEN-1:0]       LSURData,
    output logic                  ROMce,
    output logic [ADDR_WIDTH-1:0] ROMAdr,
    input  logic [XLEN-1:0]       ROMDout
`ifdef IROM_ARB_PERF_EN
    ,
    output logic [31:0]           ConflictCount,
    output logic [31:0]           SpillCount
`endif
);

    localparam int unsigned OFF = $clog2(XLEN / 8);
    localparam int unsigned HB  = OFF - 1;

    typedef enum logic [0:0] {StIdle, StSpill} state_e;

    state_e                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  rsp_q, rsp_d;
    logic                  own_ifu_q, own_ifu_d;
    logic [HB-1:0]         h_q, h_d;
    logic                  spill_q, spill_d;
    logic                  merge_q, merge_d;
    logic [15:0]           hi_q, hi_d;

    logic [ADDR_WIDTH-1:0] ifu_wadr, lsu_wadr;
    logic [HB-1:0]         ifu_h;
    logic                  straddle, ifu_win, lsu_win;
    logic [XLEN+15:0]      ext_word;

    assign ifu_wadr = IFUAdr[ADDR_WIDTH+OFF-1:OFF];
    assign lsu_wadr = LSUAdr[ADDR_WIDTH+OFF-1:OFF];
    assign ifu_h    = IFUAdr[OFF-1:1];
    assign straddle = &ifu_h;
    assign ifu_win  = IFUReq && (!LSUReq || (starve_q == 4'(STARVE_MAX)));
    assign lsu_win  = LSUReq && !ifu_win;
    // Zero pad lets the top halfword index select a 32-bit field without going out of range.
    assign ext_word = {16'h0000, ROMDout};

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        rsp_d     = 1'b0;
        own_ifu_d = own_ifu_q;
        h_d       = h_q;
        spill_d   = 1'b0;
        merge_d   = 1'b0;
        hi_d      = hi_q;
        IFUReady  = 1'b0;
        LSUReady  = 1'b0;
        ROMce     = 1'b0;
        ROMAdr    = adr_q;
        unique case (state_q)
            StIdle: begin
                IFUReady  = ifu_win;
                LSUReady  = lsu_win;
                ROMce     = ifu_win || lsu_win;
                if (ifu_win) begin
                    ROMAdr = ifu_wadr;
                end else if (lsu_win) begin
                    ROMAdr = lsu_wadr;
                end
                rsp_d     = ifu_win || lsu_win;
                own_ifu_d = ifu_win;
                h_d       = ifu_h;
                spill_d   = ifu_win && straddle;
                if (spill_d) begin
                    state_d = StSpill;
                end
                if (!IFUReq || ifu_win) begin
                    starve_d = 4'd0;
                end else begin
                    starve_d = starve_q + 4'd1;
                end
            end
            StSpill: begin
                ROMce   = 1'b1;
                ROMAdr  = adr_q + ADDR_WIDTH'(1);
                hi_d    = ROMDout[XLEN-1 -: 16];
                merge_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        adr_d = ROMAdr;
        if (reset) begin
            IFUReady = 1'b0;
            LSUReady = 1'b0;
            ROMce    = 1'b0;
            ROMAdr   = '0;
        end
    end

    always_comb begin
        IFUValid  = !reset && ((rsp_q && own_ifu_q && !spill_q) || merge_q);
        LSUValid  = !reset && rsp_q && !own_ifu_q;
        IFURData  = 32'h0;
        LSURData  = '0;
        if (IFUValid) begin
            IFURData = merge_q ? {ROMDout[15:0], hi_q} : ext_word[{h_q, 4'b0000} +: 32];
        end
        if (LSUValid) begin
            LSURData = ROMDout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            starve_q  <= 4'd0;
            adr_q     <= '0;
            rsp_q     <= 1'b0;
            own_ifu_q <= 1'b0;
            h_q       <= '0;
            spill_q   <= 1'b0;
            merge_q   <= 1'b0;
            hi_q      <= 16'h0000;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            adr_q     <= adr_d;
            rsp_q     <= rsp_d;
            own_ifu_q <= own_ifu_d;
            h_q       <= h_d;
            spill_q   <= spill_d;
            merge_q   <= merge_d;
            hi_q      <= hi_d;
        end
    end

`ifdef IROM_ARB_PERF_EN
    logic [31:0] conflict_q, spill_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q  <= 32'h0;
            spill_cnt_q <= 32'h0;
        end else begin
            if ((state_q == StIdle) && IFUReq && LSUReq && (conflict_q != 32'hFFFF_FFFF)) begin
                conflict_q <= conflict_q + 32'h1;
            end
            if (spill_d && (spill_cnt_q != 32'hFFFF_FFFF)) begin
                spill_cnt_q <= spill_cnt_q + 32'h1;
            end
        end
    end

    assign ConflictCount = conflict_q;
    assign SpillCount    = spill_cnt_q;
`endif

    logic unused_adr_bits;
    assign unused_adr_bits = ^{IFUAdr[XLEN-1:ADDR_WIDTH+OFF], IFUAdr[0],
                               LSUAdr[XLEN-1:ADDR_WIDTH+OFF], LSUAdr[OFF-1:0]};

endmodule

// File: tb/tb_irom_arb.sv
// Scoreboard bench for irom_arb: ROM model, request streams, expected-result queues.
module tb_irom_arb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 10;

    typedef struct {
        logic [63:0] data;
        int          cyc;
        int          lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            IFUReq, IFUReady, IFUValid;
    logic [XLEN-1:0] IFUAdr;
    logic [31:0]     IFURData;
    logic            LSUReq, LSUReady, LSUValid;
    logic [XLEN-1:0] LSUAdr, LSURData;
    logic            ROMce;
    logic [AW-1:0]   ROMAdr;
    logic [XLEN-1:0] ROMDout;
`ifdef IROM_ARB_PERF_EN
    logic [31:0]     conflict_count, spill_count;
`endif

    logic [XLEN-1:0] mem [2**AW];
    exp_t            qi[$], ql[$];
    logic [XLEN-1:0] ifu_s[$], lsu_s[$];
    bit              grants[$];
    int              grant_cyc[$];
    logic [AW-1:0]   adrs[$];
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    bit              ipend = 1'b0;
    bit              lpend = 1'b0;

    always #5 clk = ~clk;

    irom_arb #(.XLEN(XLEN), .ADDR_WIDTH(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .IFUReq(IFUReq), .IFUAdr(IFUAdr), .IFUReady(IFUReady),
        .IFUValid(IFUValid), .IFURData(IFURData),
        .LSUReq(LSUReq), .LSUAdr(LSUAdr), .LSUReady(LSUReady),
        .LSUValid(LSUValid), .LSURData(LSURData),
        .ROMce(ROMce), .ROMAdr(ROMAdr), .ROMDout(ROMDout)
`ifdef IROM_ARB_PERF_EN
        , .ConflictCount(conflict_count), .SpillCount(spill_count)
`endif
    );

    always @(posedge clk) if (ROMce) ROMDout <= mem[ROMAdr];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ifu_exp(input logic [XLEN-1:0] a, input int c);
        exp_t          e;
        logic [AW-1:0] w, w1;
        logic [1:0]    h;
        logic [63:0]   sh;
        w  = a[AW+2:3];
        w1 = w + 10'd1;
        h  = a[2:1];
        e.cyc = c;
        if (h == 2'd3) begin
            e.data = {32'h0, mem[w1][15:0], mem[w][63:48]};
            e.lat  = 2;
        end else begin
            sh     = mem[w] >> (16 * h);
            e.data = {32'h0, sh[31:0]};
            e.lat  = 1;
        end
        return e;
    endfunction

    // Request driver: holds each stream head until the monitor sees it accepted.
    initial begin
        IFUReq = 1'b0; LSUReq = 1'b0; IFUAdr = '0; LSUAdr = '0;
        forever begin
            @(posedge clk);
            #1;
            IFUReq = ifu_s.size() > 0;
            if (IFUReq) IFUAdr = ifu_s[0];
            LSUReq = lsu_s.size() > 0;
            if (LSUReq) LSUAdr = lsu_s[0];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            assert (!(ipend && !IFUReq)) else $error("FAIL req_drop: IFUReq dropped before accept");
            assert (!(lpend && !LSUReq)) else $error("FAIL req_drop: LSUReq dropped before accept");
        end
        check_val("one_ready", {63'h0, IFUReady & LSUReady}, 64'h0);
        if (IFUValid) begin
            if (qi.size() == 0) check_val("ifu_spurious_valid", 64'h1, 64'h0);
            else begin
                e = qi.pop_front();
                check_val("ifu_data", {32'h0, IFURData}, e.data);
                check_val("ifu_latency", 64'(cyc - e.cyc), 64'(e.lat));
            end
        end
        if (LSUValid) begin
            if (ql.size() == 0) check_val("lsu_spurious_valid", 64'h1, 64'h0);
            else begin
                e = ql.pop_front();
                check_val("lsu_data", LSURData, e.data);
                check_val("lsu_latency", 64'(cyc - e.cyc), 64'(e.lat));
            end
        end
        if (IFUReq && IFUReady) begin
            qi.push_back(ifu_exp(IFUAdr, cyc));
            void'(ifu_s.pop_front());
            grants.push_back(1'b1);
            grant_cyc.push_back(cyc);
        end
        if (LSUReq && LSUReady) begin
            e.data = mem[LSUAdr[AW+2:3]];
            e.cyc  = cyc;
            e.lat  = 1;
            ql.push_back(e);
            void'(lsu_s.pop_front());
            grants.push_back(1'b0);
            grant_cyc.push_back(cyc);
        end
        if (ROMce) adrs.push_back(ROMAdr);
        ipend = IFUReq && !IFUReady;
        lpend = LSUReq && !LSUReady;
    end

    task automatic wait_done(input int budget);
        int n = 0;
        bit busy;
        busy = 1'b1;
        while (busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            busy = (ifu_s.size() + lsu_s.size() + qi.size() + ql.size()) != 0;
        end
        check_val("drain_timeout", {63'h0, busy}, 64'h0);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grants.delete();
        grant_cyc.delete();
        adrs.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ifuvalid"}, {63'h0, IFUValid}, 64'h0);
        check_val({tag, "_lsuvalid"}, {63'h0, LSUValid}, 64'h0);
        check_val({tag, "_romce"}, {63'h0, ROMce}, 64'h0);
        check_val({tag, "_ready"}, {62'h0, IFUReady, LSUReady}, 64'h0);
        check_val({tag, "_ifurdata"}, {32'h0, IFURData}, 64'h0);
        check_val({tag, "_lsurdata"}, LSURData, 64'h0);
        check_val({tag, "_romadr"}, {54'h0, ROMAdr}, 64'h0);
    endtask

    bit exp_g[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int n;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = {16'(i) + 16'h4000, 16'(i) + 16'h3000, 16'(i) + 16'h2000, 16'(i) + 16'h1000};
        end
        mem[5] = 64'h8877_6655_4433_2211;
        mem[6] = 64'hFFEE_DDCC_9988_BBAA;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("post_reset");

        // Back-to-back non-straddling fetches within word 5.
        clear_logs();
        ifu_s.push_back(64'h28); ifu_s.push_back(64'h2A); ifu_s.push_back(64'h2C);
        wait_done(30);
        check_val("b2b_count", 64'(grants.size()), 64'd3);
        if (grants.size() == 3) begin
            check_val("b2b_gap0", 64'(grant_cyc[1] - grant_cyc[0]), 64'd1);
            check_val("b2b_gap1", 64'(grant_cyc[2] - grant_cyc[1]), 64'd1);
        end

        // Straddling fetch; LSU shows up during the spill cycle.
        clear_logs();
        ifu_s.push_back(64'h2E);
        @(negedge clk);
        #1;
        lsu_s.push_back(64'h40);
        wait_done(30);
        check_val("spill_adr_count", 64'(adrs.size()), 64'd3);
        if (adrs.size() == 3) begin
            check_val("spill_adr0", 64'(adrs[0]), 64'd5);
            check_val("spill_adr1", 64'(adrs[1]), 64'd6);
            check_val("spill_adr2", 64'(adrs[2]), 64'd8);
        end
        if (grants.size() == 2) check_val("spill_lsu_held", 64'(grant_cyc[1] - grant_cyc[0]), 64'd2);
        else check_val("spill_grants", 64'(grants.size()), 64'd2);

        // Starvation: both request, IFU forced after 4 LSU wins.
        clear_logs();
        for (int i = 10; i < 16; i++) lsu_s.push_back(64'(i * 8));
        ifu_s.push_back(64'h28); ifu_s.push_back(64'h3A);
        wait_done(40);
        check_val("starve_count", 64'(grants.size()), 64'd8);
        if (grants.size() == 8) begin
            for (int i = 0; i < 8; i++) check_val("starve_order", {63'h0, grants[i]}, {63'h0, exp_g[i]});
        end

        // Straddle at the last word wraps to word 0.
        clear_logs();
        ifu_s.push_back(64'h1FFE);
        wait_done(30);
        check_val("wrap_adr_count", 64'(adrs.size()), 64'd2);
        if (adrs.size() == 2) begin
            check_val("wrap_adr0", 64'(adrs[0]), 64'd1023);
            check_val("wrap_adr1", 64'(adrs[1]), 64'd0);
        end

        // Reset during SPILL discards the in-flight fetch.
        clear_logs();
        ifu_s.push_back(64'h2E);
        n = 0;
        while (grants.size() == 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("rst_spill_accept", 64'(grants.size()), 64'd1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        qi.delete();
        @(negedge clk);
        #1;
        check_idle_outputs("rst_spill");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_spill_noflight", 64'(qi.size()), 64'd0);
`ifdef IROM_ARB_PERF_EN
        check_val("perf_conflict_reset", {32'h0, conflict_count}, 64'd0);
        check_val("perf_spill_reset", {32'h0, spill_count}, 64'd0);
`endif
        ifu_s.push_back(64'h28);
        wait_done(30);
        check_val("rst_spill_resume", 64'(grants.size()), 64'd2);

`ifdef IROM_ARB_PERF_EN
        for (int i = 20; i < 23; i++) lsu_s.push_back(64'(i * 8));
        ifu_s.push_back(64'h28);
        wait_done(30);
        ifu_s.push_back(64'h2E); ifu_s.push_back(64'h2E);
        wait_done(30);
        check_val("perf_conflict", {32'h0, conflict_count}, 64'd3);
        check_val("perf_spill", {32'h0, spill_count}, 64'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irom_arb.md
Name: irom_arb

Overview:
- Single-port arbiter and sequencer in front of the instruction ROM (rom1p1r, 1-cycle read latency, XLEN-wide words).
- Shares the ROM between two requesters:
  - IFU instruction fetch: 32-bit result, halfword-aligned address, may straddle two ROM words.
  - LSU data read: one full XLEN word.
- Issues at most one ROM read per cycle, performs the two-read spill merge for straddling fetches, and returns tagged, registered responses.

Parameters:
- XLEN, 64, data width and ROM word width; 32 or 64 only.
- ADDR_WIDTH, 10, ROM word-address width.
- STARVE_MAX, 4, consecutive IFU denials before the IFU is forced ahead of the LSU; range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- IFUReq  input  1  fetch request; held with IFUAdr stable until accepted
- IFUAdr  input  XLEN  fetch byte address; bit 0 ignored
- IFUReady  output  1  fetch accepted this cycle when IFUReq && IFUReady
- IFUValid  output  1  IFURData valid, one-cycle pulse
- IFURData  output  32  fetched instruction bits, little-endian
- LSUReq  input  1  data read request; held with LSUAdr stable until accepted
- LSUAdr  input  XLEN  data byte address; low log2(XLEN/8) bits ignored
- LSUReady  output  1  read accepted this cycle
- LSUValid  output  1  LSURData valid, one-cycle pulse
- LSURData  output  XLEN  ROM word
- ROMce  output  1  ROM chip enable
- ROMAdr  output  ADDR_WIDTH  ROM word address
- ROMDout  input  XLEN  ROM read data, valid the cycle after ROMce

Interface decision: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Definitions:
  - OFF = log2(XLEN/8).
  - Word address = Adr[ADDR_WIDTH+OFF-1:OFF].
  - Half index h:
    - XLEN=64: h = IFUAdr[2:1]
    - XLEN=32: h = IFUAdr[1]
  - Straddle: XLEN=64 with h==3, or XLEN=32 with h==1.
- FSM states IDLE, SPILL:
  - IDLE:
    - Arbitrates and issues: ROMce=1, ROMAdr=winner word address.
    - Winner's Ready=1 the same cycle (combinational from state, requests, starvation counter).
    - Non-straddling IFU fetch or any LSU read: stay IDLE. Back-to-back accepts every cycle are allowed, so throughput is 1 per cycle.
    - Straddling IFU fetch: go to SPILL.
  - SPILL:
    - Issues word address +1 (wraps modulo 2^ADDR_WIDTH).
    - Both Ready outputs are 0.
    - Returns to IDLE next cycle.
- Response pipeline:
  - Registered tag captured at issue: owner, h, spill flag.
  - Non-spill response, the cycle after accept:
    - Valid pulses.
    - IFURData = 32-bit field selected by h; an odd halfword offset selects the bits starting at halfword h.
    - LSURData = ROMDout.
  - Spill:
    - Cycle after accept: upper halfword of word A latched, no Valid.
    - Following cycle: IFUValid=1, IFURData = {ROMDout[15:0], latched halfword}.
    - Spill latency is 2 cycles.
- Arbitration:
  - LSU has priority by default.
  - Starvation counter (4 bits) increments each IDLE cycle in which IFUReq=1 and the LSU wins.
  - The counter clears when the IFU is granted or IFUReq=0.
  - When counter==STARVE_MAX and both request, the IFU wins.
  - The counter does not change in SPILL.
- Sole requester always wins in IDLE. No request: ROMce=0, ROMAdr holds its last value.
- Reset values:
  - State IDLE, counter 0.
  - IFUValid, LSUValid, ROMce, IFUReady, LSUReady all 0.
  - IFURData, LSURData, ROMAdr all 0.
- Reset mid-operation, including during SPILL or with a response pending: the in-flight read is discarded, no Valid is ever produced for it, and the cycle after reset deasserts is IDLE.
- A Req dropped before acceptance is illegal; behaviour is unspecified and flagged by a bench assertion.
- Reset has precedence over everything.

Optional Feature:
- Macro: IROM_ARB_PERF_EN.
- Defined:
  - Adds output ConflictCount [31:0]: saturating count of IDLE cycles in which IFUReq and LSUReq are both 1.
  - Adds output SpillCount [31:0]: saturating count of spill fetches.
  - Both counters cleared by reset.
- Undefined: neither port nor any counter logic exists. Functional behaviour is identical with or without the macro.

Test Plan:
- XLEN=64, ROM word 5 = 0x8877665544332211. IFU fetches 0x28, 0x2A, 0x2C back to back → one accept per cycle; IFURData = 0x44332211, 0x66554433, 0x88776655 on consecutive cycles after a 1-cycle latency.
- Straddle: word 5 as above, word 6 = 0x...BBAA. IFU fetch 0x2E → IFUReady 1 in cycle 0, ROMAdr 5 then 6, IFUValid only in cycle 2 with IFURData = 0xBBAA8877; LSUReady=0 in cycle 1 even though LSUReq=1.
- Starvation, STARVE_MAX=4: both requesting continuously → LSU granted 4 cycles, IFU granted on the 5th, counter back to 0, then LSU again.
- Wrap: IFU straddle at the last word (2^ADDR_WIDTH−1) → second read is ROMAdr 0, and the data is merged correctly.
- Reset asserted during SPILL → no IFUValid afterwards, all outputs 0; next request serviced normally.
- With IROM_ARB_PERF_EN: 3 conflict cycles plus 2 spills → ConflictCount=3, SpillCount=2; both counters 0 after reset.
